// File: rtl/rdata_fwft.sv
// First-word-fall-through output stage for the read side of an async FIFO.
// Pops words into a head/skid register pair and presents them on valid/ready with registered outputs.
module rdata_fwft #(
    parameter int DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    input  logic                rflush,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATASIZE-1:0] rdout,
    output logic [1:0]          rcount
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [DATASIZE-1:0] head_reg;
    logic [DATASIZE-1:0] head_next;
    logic [DATASIZE-1:0] skid_reg;
    logic [DATASIZE-1:0] skid_next;
    logic                pop_in;
    logic                pop_out;

    // Pop decision deliberately ignores rready so the read pointer never sees a path from the consumer.
    assign rinc    = ~rempty & ~rrst & ~rflush & (state_reg != TWO);
    assign pop_in  = rinc;
    assign rvalid  = (state_reg != EMPTY);
    assign pop_out = rvalid & rready;
    assign rdout   = head_reg;
    assign rcount  = state_reg;

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        if (rflush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (pop_in) begin
                        head_next  = rdata;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (pop_in && pop_out) begin
                        head_next = rdata;
                    end else if (pop_in) begin
                        skid_next  = rdata;
                        state_next = TWO;
                    end else if (pop_out) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    // No pop can happen here, so the skid word simply moves up to the head.
                    if (pop_out) begin
                        head_next  = skid_reg;
                        state_next = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_reg <= EMPTY;
            head_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
        end
    end

endmodule

// File: tb/tb_rdata_fwft.sv
// Directed table plus randomized queue-model checks for rdata_fwft.
// One line per failing comparison, one summary line at the end.
module tb_rdata_fwft;

    localparam int W = 8;

    logic         rclk = 1'b0;
    logic         rrst;
    logic         rempty;
    logic [W-1:0] rdata;
    logic         rinc;
    logic         rflush;
    logic         rvalid;
    logic         rready;
    logic [W-1:0] rdout;
    logic [1:0]   rcount;

    int checks = 0;
    int errors = 0;

    rdata_fwft #(.DATASIZE(W)) dut (
        .rclk   (rclk),
        .rrst   (rrst),
        .rempty (rempty),
        .rdata  (rdata),
        .rinc   (rinc),
        .rflush (rflush),
        .rvalid (rvalid),
        .rready (rready),
        .rdout  (rdout),
        .rcount (rcount)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic         rst;
        logic         empty;
        logic [W-1:0] data;
        logic         ready;
        logic         flush;
        logic         e_rinc;
        logic         e_valid;
        logic [1:0]   e_count;
        logic [W-1:0] e_dout;
        logic         chk_dout;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic empty, input logic [W-1:0] data,
                                input logic ready, input logic flush, input logic e_rinc,
                                input logic e_valid, input logic [1:0] e_count,
                                input logic [W-1:0] e_dout, input logic chk_dout);
        vec_t v;
        v.rst = rst; v.empty = empty; v.data = data; v.ready = ready; v.flush = flush;
        v.e_rinc = e_rinc; v.e_valid = e_valid; v.e_count = e_count;
        v.e_dout = e_dout; v.chk_dout = chk_dout;
        return v;
    endfunction

    logic [W-1:0] memq[$];
    logic [W-1:0] refq[$];

    initial begin
        logic         exp_rinc;
        logic         did_out;
        logic         stall;
        logic [W-1:0] prev_dout;
        logic [W-1:0] next_word;

        //            rst emp data   rdy fl | rinc vld cnt dout  chk
        // reset with FIFO non-empty, then stream 11..44 at full rate
        vecs[0]  = mk(1, 0, 8'h11, 0, 0,   0, 0, 2'd0, 8'h00, 1);
        vecs[1]  = mk(1, 0, 8'h11, 0, 0,   0, 0, 2'd0, 8'h00, 1);
        vecs[2]  = mk(0, 0, 8'h11, 1, 0,   1, 1, 2'd1, 8'h11, 1);
        vecs[3]  = mk(0, 0, 8'h22, 1, 0,   1, 1, 2'd1, 8'h22, 1);
        vecs[4]  = mk(0, 0, 8'h33, 1, 0,   1, 1, 2'd1, 8'h33, 1);
        vecs[5]  = mk(0, 0, 8'h44, 1, 0,   1, 1, 2'd1, 8'h44, 1);
        vecs[6]  = mk(0, 1, 8'h00, 1, 0,   0, 0, 2'd0, 8'h00, 0);
        // back-pressure: A1..A3 with rready low for 3 cycles
        vecs[7]  = mk(0, 0, 8'hA1, 0, 0,   1, 1, 2'd1, 8'hA1, 1);
        vecs[8]  = mk(0, 0, 8'hA2, 0, 0,   1, 1, 2'd2, 8'hA1, 1);
        vecs[9]  = mk(0, 0, 8'hA3, 0, 0,   0, 1, 2'd2, 8'hA1, 1);
        vecs[10] = mk(0, 0, 8'hA3, 0, 0,   0, 1, 2'd2, 8'hA1, 1);
        vecs[11] = mk(0, 0, 8'hA3, 1, 0,   0, 1, 2'd1, 8'hA2, 1);
        vecs[12] = mk(0, 0, 8'hA3, 1, 0,   1, 1, 2'd1, 8'hA3, 1);
        vecs[13] = mk(0, 1, 8'h00, 1, 0,   0, 0, 2'd0, 8'h00, 0);
        // flush with 55,66 buffered and 77 still in memory
        vecs[14] = mk(0, 0, 8'h55, 0, 0,   1, 1, 2'd1, 8'h55, 1);
        vecs[15] = mk(0, 0, 8'h66, 0, 0,   1, 1, 2'd2, 8'h55, 1);
        vecs[16] = mk(0, 0, 8'h77, 0, 0,   0, 1, 2'd2, 8'h55, 1);
        vecs[17] = mk(0, 0, 8'h77, 1, 1,   0, 0, 2'd0, 8'h00, 0);
        vecs[18] = mk(0, 0, 8'h77, 0, 0,   1, 1, 2'd1, 8'h77, 1);
        vecs[19] = mk(0, 1, 8'h00, 1, 0,   0, 0, 2'd0, 8'h00, 0);
        // reset mid-stream, asserted together with flush
        vecs[20] = mk(0, 0, 8'h5A, 0, 0,   1, 1, 2'd1, 8'h5A, 1);
        vecs[21] = mk(0, 0, 8'h5B, 0, 0,   1, 1, 2'd2, 8'h5A, 1);
        vecs[22] = mk(1, 0, 8'h5C, 1, 1,   0, 0, 2'd0, 8'h00, 1);
        vecs[23] = mk(0, 1, 8'h00, 0, 0,   0, 0, 2'd0, 8'h00, 1);

        rrst = 1'b1; rempty = 1'b1; rdata = '0; rready = 1'b0; rflush = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge rclk);
            rrst = vecs[i].rst; rempty = vecs[i].empty; rdata = vecs[i].data;
            rready = vecs[i].ready; rflush = vecs[i].flush;
            #2;
            check($sformatf("vec%0d rinc", i), 32'(rinc), 32'(vecs[i].e_rinc));
            @(posedge rclk);
            #1;
            check($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d rcount", i), 32'(rcount), 32'(vecs[i].e_count));
            if (vecs[i].chk_dout)
                check($sformatf("vec%0d rdout", i), 32'(rdout), 32'(vecs[i].e_dout));
        end

        // empty guard: rready toggling while the FIFO stays empty
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            rrst = 1'b0; rflush = 1'b0; rempty = 1'b1; rdata = 8'hEE; rready = i[0];
            #2;
            check($sformatf("guard%0d rinc", i), 32'(rinc), 32'd0);
            @(posedge rclk);
            #1;
            check($sformatf("guard%0d rvalid", i), 32'(rvalid), 32'd0);
        end

        // random traffic against a reference queue; DUT starts EMPTY here
        next_word = 8'h01;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge rclk);
            if (memq.size() < 8) begin
                int n;
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    memq.push_back(next_word);
                    next_word = next_word + 8'd1;
                end
            end
            rrst   = 1'b0;
            rempty = (memq.size() == 0) || ($urandom_range(0, 3) == 0);
            rdata  = rempty ? W'($urandom) : memq[0];
            rready = ($urandom_range(0, 2) != 0);
            rflush = ($urandom_range(0, 199) == 0);
            #2;
            exp_rinc = !rempty && !rflush && (refq.size() != 2);
            check("rand rinc", 32'(rinc), 32'(exp_rinc));
            did_out   = rvalid && rready;
            stall     = rvalid && !rready && !rflush;
            prev_dout = rdout;
            @(posedge rclk);
            #1;
            if (rflush) begin
                refq.delete();
            end else begin
                if (did_out && refq.size() != 0) void'(refq.pop_front());
                if (exp_rinc) refq.push_back(memq.pop_front());
            end
            check("rand rcount", 32'(rcount), 32'(refq.size()));
            check("rand rvalid", 32'(rvalid), 32'(refq.size() != 0));
            if (refq.size() != 0)
                check("rand rdout order", 32'(rdout), 32'(refq[0]));
            if (stall)
                check("rand rdout stable", 32'(rdout), 32'(prev_dout));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
